// File: rtl/adc_recorder.sv
// adc_recorder: captures 16-bit I2S samples from an audio codec ADC and
// writes them sequentially into an 18-bit-addressed SRAM.
// Optional feature: define ADC_RECORDER_STEREO_EN to capture the right
// channel as well (interleaved L, R, L, R); by default only left is kept.
module adc_recorder (
    input  logic        bclk,
    input  logic        rst_n,
    input  logic        adcon,
    input  logic        adclrc,
    input  logic        adcdat,
    output logic [17:0] addr,
    output logic [15:0] data,
    output logic        write,
    output logic        full
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] WAIT_LRC = 3'd1;
    localparam logic [2:0] SHIFT    = 3'd2;
    localparam logic [2:0] STORE    = 3'd3;
    localparam logic [2:0] FULL     = 3'd4;

    localparam logic [17:0] LAST_ADDR = 18'h3FFFF;

    logic [2:0]  state;
    logic        lrc_d;
    logic [3:0]  bit_cnt;
    logic [14:0] shreg;
    logic        left_start;
    logic        right_start;
    logic        slot_start;

    // A falling adclrc marks the start of the left slot; the MSB follows
    // one bclk later (I2S one-bit delay).
    assign left_start = lrc_d & ~adclrc;
`ifdef ADC_RECORDER_STEREO_EN
    assign right_start = ~lrc_d & adclrc;
`else
    assign right_start = 1'b0;
`endif
    assign slot_start = left_start | right_start;

    // Previous adclrc value for edge detection; idles high so a fresh
    // falling edge is needed after reset.
    always_ff @(posedge bclk or negedge rst_n) begin
        if (!rst_n) begin
            lrc_d <= 1'b1;
        end else begin
            lrc_d <= adclrc;
        end
    end

    // Capture FSM: wait for a slot start, shift in 16 bits, strobe the
    // SRAM write, then advance the address or stop when memory is full.
    always_ff @(posedge bclk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            addr    <= '0;
            data    <= '0;
            write   <= 1'b0;
            full    <= 1'b0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            write <= 1'b0;
            if (!adcon) begin
                // Any partial word is dropped; addr is left untouched.
                state   <= IDLE;
                full    <= 1'b0;
                bit_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        addr  <= '0;
                        full  <= 1'b0;
                        state <= WAIT_LRC;
                    end
                    WAIT_LRC: begin
                        if (slot_start) begin
                            bit_cnt <= '0;
                            state   <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (bit_cnt == 4'd15) begin
                            data  <= {shreg, adcdat};
                            write <= 1'b1;
                            state <= STORE;
                        end else begin
                            shreg   <= {shreg[13:0], adcdat};
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    STORE: begin
                        if (addr == LAST_ADDR) begin
                            full  <= 1'b1;
                            state <= FULL;
                        end else begin
                            addr  <= addr + 18'd1;
                            state <= WAIT_LRC;
                        end
                    end
                    FULL: begin
                        full <= 1'b1;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adc_recorder.sv
// Self-checking bench for adc_recorder: table-driven I2S frames plus
// hand-written abort, reset and memory-full sequences. A scoreboard queue
// holds the {addr, data} of every write the stimulus should produce.
module tb_adc_recorder;

`ifdef ADC_RECORDER_STEREO_EN
    localparam bit STEREO = 1'b1;
`else
    localparam bit STEREO = 1'b0;
`endif
    localparam int PER = STEREO ? 2 : 1;

    logic        bclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        adcon = 1'b0;
    logic        adclrc = 1'b1;
    logic        adcdat = 1'b0;
    logic [17:0] addr;
    logic [15:0] data;
    logic        write;
    logic        full;

    adc_recorder dut (
        .bclk   (bclk),
        .rst_n  (rst_n),
        .adcon  (adcon),
        .adclrc (adclrc),
        .adcdat (adcdat),
        .addr   (addr),
        .data   (data),
        .write  (write),
        .full   (full)
    );

    always #5 bclk = ~bclk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [33:0] exp_q[$];
    logic [17:0] mdl_addr = '0;
    bit          mdl_full = 1'b0;

    typedef struct {
        logic [15:0] left;
        logic [15:0] right;
        logic [17:0] addr_after;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest expectation.
    always @(negedge bclk) begin
        if (write === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: addr %h data %h, expected no write", addr, data);
            end else begin
                logic [33:0] e;
                e = exp_q.pop_front();
                chk("write_addr", {14'd0, addr}, {14'd0, e[33:16]});
                chk("write_data", {16'd0, data}, {16'd0, e[15:0]});
            end
        end
    end

    task automatic drive(input logic lrc, input logic dat);
        @(negedge bclk);
        adclrc = lrc;
        adcdat = dat;
    endtask

    // Slot start cycle, then the first nbits of word MSB first.
    task automatic slot_part(input logic lrc, input logic [15:0] word, input int nbits);
        drive(lrc, 1'b0);
        for (int i = 0; i < nbits; i++) drive(lrc, word[15 - i]);
    endtask

    // Trailing bits of a slot: ones that the recorder must ignore.
    task automatic fill(input logic lrc, input int n);
        for (int i = 0; i < n; i++) drive(lrc, 1'b1);
    endtask

    task automatic expect_word(input logic [15:0] w);
        if (!mdl_full) begin
            exp_q.push_back({mdl_addr, w});
            if (mdl_addr == 18'h3FFFF) mdl_full = 1'b1;
            else mdl_addr = mdl_addr + 18'd1;
        end
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
        expect_word(l);
        if (STEREO) expect_word(r);
        slot_part(1'b0, l, 16);
        fill(1'b0, 15);
        slot_part(1'b1, r, 16);
        fill(1'b1, 15);
    endtask

    vec_t tbl[5];

    initial begin
        tbl[0] = '{16'hA5C3, 16'h5A5A, STEREO ? 18'd2  : 18'd1};
        tbl[1] = '{16'h0001, 16'h7E7E, STEREO ? 18'd4  : 18'd2};
        tbl[2] = '{16'h8000, 16'h0F0F, STEREO ? 18'd6  : 18'd3};
        tbl[3] = '{16'hFFFF, 16'h0000, STEREO ? 18'd8  : 18'd4};
        tbl[4] = '{16'h1234, 16'h5678, STEREO ? 18'd10 : 18'd5};

        // Reset state
        #12;
        chk("rst_addr",  {14'd0, addr}, 32'd0);
        chk("rst_data",  {16'd0, data}, 32'd0);
        chk("rst_write", {31'd0, write}, 32'd0);
        chk("rst_full",  {31'd0, full}, 32'd0);
        @(negedge bclk);
        rst_n = 1'b1;
        repeat (3) @(negedge bclk);
        chk("idle_addr", {14'd0, addr}, 32'd0);

        // Table-driven frames
        adcon = 1'b1;
        repeat (4) drive(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (STEREO) begin
                exp_q.push_back({tbl[i].addr_after - 18'd2, tbl[i].left});
                exp_q.push_back({tbl[i].addr_after - 18'd1, tbl[i].right});
            end else begin
                exp_q.push_back({tbl[i].addr_after - 18'd1, tbl[i].left});
            end
            slot_part(1'b0, tbl[i].left, 16);
            fill(1'b0, 15);
            slot_part(1'b1, tbl[i].right, 16);
            fill(1'b1, 15);
            chk("frame_addr_after", {14'd0, addr}, {14'd0, tbl[i].addr_after});
        end
        mdl_addr = tbl[4].addr_after;

        // adcon dropped after 8 bits: no write, addr kept
        slot_part(1'b0, 16'hC3C3, 8);
        adcon = 1'b0;
        fill(1'b0, 23);
        chk("abort_addr_kept", {14'd0, addr}, {14'd0, mdl_addr});
        fill(1'b1, 28);
        adcon = 1'b1;
        fill(1'b1, 3);
        chk("reenable_addr", {14'd0, addr}, 32'd0);
        chk("reenable_full", {31'd0, full}, 32'd0);
        mdl_addr = '0;
        send_frame(16'h3C5A, 16'h9999);
        chk("after_reenable_addr", {14'd0, addr}, PER);

        // Reset pulse after 10 bits of a sample
        slot_part(1'b0, 16'hBEEF, 10);
        #2;
        rst_n = 1'b0;
        adcon = 1'b0;
        #1;
        chk("midrst_addr",  {14'd0, addr}, 32'd0);
        chk("midrst_data",  {16'd0, data}, 32'd0);
        chk("midrst_write", {31'd0, write}, 32'd0);
        chk("midrst_full",  {31'd0, full}, 32'd0);
        fill(1'b0, 3);
        rst_n = 1'b1;
        fill(1'b0, 18);
        fill(1'b1, 28);
        adcon = 1'b1;
        fill(1'b1, 3);
        mdl_addr = '0;
        send_frame(16'h0F0F, 16'hF0F0);
        chk("after_reset_addr", {14'd0, addr}, PER);

        // Preload the address near the top of memory, then fill it
        @(negedge bclk);
        force dut.addr = 18'h3FFFE;
        @(negedge bclk);
        @(negedge bclk);
        release dut.addr;
        mdl_addr = 18'h3FFFE;
        chk("preload_addr", {14'd0, addr}, 32'h3FFFE);
        send_frame(16'h1111, 16'h2222);
        if (!STEREO) send_frame(16'h3333, 16'h4444);
        send_frame(16'h5555, 16'h6666);
        chk("full_set",  {31'd0, full}, 32'd1);
        chk("full_addr", {14'd0, addr}, 32'h3FFFF);
        adcon = 1'b0;
        repeat (3) @(negedge bclk);
        chk("full_cleared", {31'd0, full}, 32'd0);

        repeat (4) @(negedge bclk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Overall time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
